// File: rtl/dmem_seq_pkg.sv
// Shared definitions for the DMem address/control sequencer:
// default widths, command mode and select encodings, and the FSM state type.
package dmem_seq_pkg;

    localparam int ADDR_DMEM = 8;   // DMem address width; bank depth is 2**ADDR_DMEM
    localparam int LEN_WIDTH = 9;   // burst length width; holds a full-bank length
    localparam int LAT_WIDTH = 4;   // RDWR write-back delay width

    typedef enum logic [1:0] {
        MODE_WRITE = 2'b00,         // load the bank from the array
        MODE_READ  = 2'b01,         // drain the bank to the array
        MODE_RDWR  = 2'b10,         // read, then write back after the ring latency
        MODE_RSVD  = 2'b11          // reserved; behaves as an empty burst
    } mode_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_V    = 2'b10;
    localparam logic [1:0] SEL_H    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Direction bit (0 vertical, 1 horizontal) to a RAM port select code.
    function automatic logic [1:0] sel_of(input logic dir);
        return dir ? SEL_H : SEL_V;
    endfunction

endpackage

// File: rtl/dmem_seq_if.sv
// Burst command channel between the layer controller (master) and the
// DMem sequencer (slave): valid/ready handshake plus the command fields.
interface dmem_seq_if
    import dmem_seq_pkg::*;
#(
    parameter int AddrDMEM = ADDR_DMEM,
    parameter int LenWidth = LEN_WIDTH,
    parameter int LatWidth = LAT_WIDTH
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_mode;
    logic                cmd_dir;
    logic [AddrDMEM-1:0] cmd_raddr;
    logic [AddrDMEM-1:0] cmd_waddr;
    logic [AddrDMEM-1:0] cmd_stride;
    logic [LenWidth-1:0] cmd_len;
    logic [LatWidth-1:0] cmd_lat;

    modport master (
        output cmd_valid, cmd_mode, cmd_dir, cmd_raddr, cmd_waddr,
               cmd_stride, cmd_len, cmd_lat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_dir, cmd_raddr, cmd_waddr,
               cmd_stride, cmd_len, cmd_lat,
        output cmd_ready
    );

endinterface

// File: rtl/dmem_seq_addr_gen.sv
// Base/stride address counter. Load captures base and stride, advance adds
// the stride (wrapping at the address width), hold freezes the count.
// The counter register is the address presented to the DMem port.
module dmem_addr_gen
    import dmem_seq_pkg::*;
#(
    parameter int AddrDMEM = ADDR_DMEM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic [AddrDMEM-1:0] i_base,
    input  logic [AddrDMEM-1:0] i_stride,
    input  logic                i_adv,
    input  logic                i_hold,
    output logic [AddrDMEM-1:0] o_addr
);

    logic [AddrDMEM-1:0] r_addr_q;
    logic [AddrDMEM-1:0] r_stride;

    // Address counter: clear, load, or step by the latched stride.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_addr_q <= '0;
            r_stride <= '0;
        end else if (i_load) begin
            r_addr_q <= i_base;
            r_stride <= i_stride;
        end else if (i_adv && !i_hold) begin
            // Same-width add: the carry out is dropped, giving modulo wrap.
            r_addr_q <= r_addr_q + r_stride;
        end
    end

    assign o_addr = r_addr_q;

endmodule

// File: rtl/dmem_seq.sv
// DMem bank sequencer. Accepts one burst command at a time and streams
// read/write addresses, write enable and port selects for the whole burst.
// All DMem-side outputs are registered: each edge computes the beat that
// will be presented during the following cycle.
module dmem_seq
    import dmem_seq_pkg::*;
#(
    parameter int AddrDMEM = ADDR_DMEM,
    parameter int LenWidth = LEN_WIDTH,
    parameter int LatWidth = LAT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    dmem_seq_if.slave           cmd,
    input  logic                stall,
    output logic [AddrDMEM-1:0] r_addr,
    output logic [AddrDMEM-1:0] w_addr,
    output logic                we_ram,
    output logic [1:0]          sel_ram_i,
    output logic [1:0]          sel_ram_o,
    output logic                busy,
    output logic                done
);

    // One history bit per possible delay value, so hist[lat] is always valid.
    localparam int HistW = 2**LatWidth;

    state_e              r_state;
    mode_e               r_mode;
    logic                r_dir;
    logic [LenWidth-1:0] r_len;
    logic [LatWidth-1:0] r_lat;
    logic [LenWidth-1:0] r_rd_cnt;   // read beats issued, including the current cycle
    logic [LenWidth-1:0] r_wr_cnt;   // write beats issued, including the current cycle
    logic [HistW-1:0]    r_rd_hist;  // bit j: a read beat was presented j active cycles ago
    logic                r_we;
    logic [1:0]          r_sel_i;
    logic [1:0]          r_sel_o;
    logic                r_busy;
    logic                r_done;

    logic                w_in_burst;
    logic                w_accept;
    logic                w_acc_empty;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic [1:0]          w_acc_src;
    logic                w_finished;
    logic                w_rd_next;
    logic                w_wr_next;
    logic [HistW-1:0]    w_hist_shift;
    logic                w_step;
    logic                w_end;
    logic                w_rd_adv;
    logic                w_wr_adv;
    logic [1:0]          w_src_sel;

    // Next-beat decisions shared by the FSM and the two address counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_in_burst   = 1'b0;
        w_accept     = 1'b0;
        w_acc_empty  = 1'b0;
        w_acc_rd     = 1'b0;
        w_acc_wr     = 1'b0;
        w_acc_src    = SEL_NONE;
        w_finished   = 1'b0;
        w_rd_next    = 1'b0;
        w_wr_next    = 1'b0;
        w_hist_shift = '0;
        w_src_sel    = SEL_NONE;

        w_in_burst  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_accept    = (r_state == ST_IDLE) && cmd.cmd_valid;
        w_acc_empty = (cmd.cmd_len == '0) || (cmd.cmd_mode == MODE_RSVD);
        w_acc_rd    = (cmd.cmd_mode == MODE_READ) || (cmd.cmd_mode == MODE_RDWR);
        // With zero delay the first RDWR write shares the cycle of the first read.
        w_acc_wr    = (cmd.cmd_mode == MODE_WRITE) ||
                      ((cmd.cmd_mode == MODE_RDWR) && (cmd.cmd_lat == '0));
        w_acc_src   = (cmd.cmd_mode == MODE_RDWR) ? sel_of(~cmd.cmd_dir) : sel_of(cmd.cmd_dir);

        // The burst ends on its last write beat, or last read beat for READ.
        w_finished = (r_mode == MODE_READ) ? (r_rd_cnt == r_len) : (r_wr_cnt == r_len);
        w_rd_next  = ((r_mode == MODE_READ) || (r_mode == MODE_RDWR)) && (r_rd_cnt != r_len);

        // After shifting, bit 0 is the next cycle's read and bit lat is the read
        // issued lat active cycles before it, which is what RDWR writes back.
        w_hist_shift = {r_rd_hist[HistW-2:0], w_rd_next};
        case (r_mode)
            MODE_WRITE: w_wr_next = (r_wr_cnt != r_len);
            MODE_RDWR:  w_wr_next = w_hist_shift[r_lat];
            default:    w_wr_next = 1'b0;
        endcase

        w_src_sel = (r_mode == MODE_RDWR) ? sel_of(~r_dir) : sel_of(r_dir);
    end

    assign w_step   = w_in_burst && !stall && !w_finished;
    assign w_end    = w_in_burst && !stall && w_finished;
    // The first beat presents the loaded base, so only later beats advance.
    assign w_rd_adv = w_step && w_rd_next && (r_rd_cnt != '0);
    assign w_wr_adv = w_step && w_wr_next && (r_wr_cnt != '0);

    dmem_addr_gen #(.AddrDMEM(AddrDMEM)) u_rd_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_end),
        .i_load   (w_accept && !w_acc_empty),
        .i_base   (cmd.cmd_raddr),
        .i_stride (cmd.cmd_stride),
        .i_adv    (w_rd_adv),
        .i_hold   (stall),
        .o_addr   (r_addr)
    );

    dmem_addr_gen #(.AddrDMEM(AddrDMEM)) u_wr_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_end),
        .i_load   (w_accept && !w_acc_empty),
        .i_base   (cmd.cmd_waddr),
        .i_stride (cmd.cmd_stride),
        .i_adv    (w_wr_adv),
        .i_hold   (stall),
        .o_addr   (w_addr)
    );

    // Burst FSM with registered beat outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_WRITE;
            r_dir     <= 1'b0;
            r_len     <= '0;
            r_lat     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_hist <= '0;
            r_we      <= 1'b0;
            r_sel_i   <= SEL_NONE;
            r_sel_o   <= SEL_NONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mode <= mode_e'(cmd.cmd_mode);
                        r_dir  <= cmd.cmd_dir;
                        r_len  <= cmd.cmd_len;
                        r_lat  <= cmd.cmd_lat;
                        if (w_acc_empty) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            r_busy    <= 1'b1;
                            r_rd_cnt  <= LenWidth'(w_acc_rd);
                            r_wr_cnt  <= LenWidth'(w_acc_wr);
                            r_rd_hist <= HistW'(w_acc_rd);
                            r_we      <= w_acc_wr;
                            r_sel_o   <= w_acc_rd ? sel_of(cmd.cmd_dir) : SEL_NONE;
                            r_sel_i   <= w_acc_wr ? w_acc_src : SEL_NONE;
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (stall) begin
                        // Bubble: counters, pipe and read select hold; no write.
                        r_we <= 1'b0;
                    end else if (w_finished) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_we    <= 1'b0;
                        r_sel_i <= SEL_NONE;
                        r_sel_o <= SEL_NONE;
                    end else begin
                        r_state   <= ((r_mode == MODE_RDWR) && !w_rd_next) ? ST_DRAIN : ST_RUN;
                        r_rd_cnt  <= r_rd_cnt + LenWidth'(w_rd_next);
                        r_wr_cnt  <= r_wr_cnt + LenWidth'(w_wr_next);
                        r_rd_hist <= w_hist_shift;
                        r_we      <= w_wr_next;
                        r_sel_o   <= w_rd_next ? sel_of(r_dir) : SEL_NONE;
                        r_sel_i   <= w_wr_next ? w_src_sel : SEL_NONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign we_ram        = r_we;
    assign sel_ram_i     = r_sel_i;
    assign sel_ram_o     = r_sel_o;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_dmem_seq.sv
// Self-checking bench for dmem_seq: directed bursts from the test plan plus
// randomized commands and stall patterns, checked against a beat-schedule
// reference model (read k at active cycle k+1, write k at k+1 or k+1+lat).
module tb_dmem_seq;
    import dmem_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [7:0] r_addr;
    logic [7:0] w_addr;
    logic       we_ram;
    logic [1:0] sel_ram_i;
    logic [1:0] sel_ram_o;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_seq_if cmd_if ();

    dmem_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .stall     (stall),
        .r_addr    (r_addr),
        .w_addr    (w_addr),
        .we_ram    (we_ram),
        .sel_ram_i (sel_ram_i),
        .sel_ram_o (sel_ram_o),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string where);
        check({where, " cmd_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
        check({where, " r_addr"},    32'(r_addr),    32'd0);
        check({where, " w_addr"},    32'(w_addr),    32'd0);
        check({where, " we_ram"},    32'(we_ram),    32'd0);
        check({where, " sel_ram_i"}, 32'(sel_ram_i), 32'd0);
        check({where, " sel_ram_o"}, 32'(sel_ram_o), 32'd0);
        check({where, " busy"},      32'(busy),      32'd0);
        check({where, " done"},      32'(done),      32'd0);
    endtask

    // Offer one command, then check every cycle of the burst against the
    // beat schedule. stall_mask bit c drives stall during burst cycle c.
    task automatic run_cmd(input string name, input logic [1:0] mode, input logic dir,
                           input logic [7:0] ra, input logic [7:0] wa, input logic [7:0] st,
                           input logic [8:0] len, input logic [3:0] lat,
                           input logic [63:0] stall_mask, input bit hold_valid);
        int         t_last;
        int         t;
        int         k;
        int         kw;
        bit         fin;
        bit         bubble;
        bit         prev_stall;
        bit         rd_mode;
        logic       exp_we;
        logic [1:0] exp_sel_i;
        logic [1:0] exp_sel_o;
        logic [7:0] exp_ra;
        logic [7:0] exp_wa;
        logic [1:0] prev_sel_o;
        logic [7:0] prev_ra;

        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = mode;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_raddr  = ra;
        cmd_if.cmd_waddr  = wa;
        cmd_if.cmd_stride = st;
        cmd_if.cmd_len    = len;
        cmd_if.cmd_lat    = lat;
        stall             = 1'b0;
        @(negedge clk);
        check_idle({name, " idle"});
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = hold_valid;

        rd_mode = (mode == MODE_READ) || (mode == MODE_RDWR);
        if (len == 0 || mode == MODE_RSVD) t_last = 0;
        else if (mode == MODE_RDWR)        t_last = int'(len) + int'(lat);
        else                               t_last = int'(len);

        t          = 0;
        fin        = 1'b0;
        prev_stall = 1'b0;
        prev_sel_o = SEL_NONE;
        prev_ra    = '0;
        for (int c = 1; c < 2000 && !fin; c++) begin
            stall = (c < 64) ? stall_mask[c[5:0]] : 1'b0;
            if (t >= 1 && prev_stall) bubble = 1'b1;
            else begin
                bubble = 1'b0;
                t++;
            end
            @(negedge clk);
            if (t > t_last) begin
                check({name, " done"},      32'(done),      32'd1);
                check({name, " done busy"}, 32'(busy),      32'd0);
                check({name, " done we"},   32'(we_ram),    32'd0);
                check({name, " done seli"}, 32'(sel_ram_i), 32'd0);
                check({name, " done selo"}, 32'(sel_ram_o), 32'd0);
                check({name, " done rdy"},  32'(cmd_if.cmd_ready), 32'd0);
                fin = 1'b1;
            end else if (bubble) begin
                check({name, " stall we"},   32'(we_ram),    32'd0);
                check({name, " stall selo"}, 32'(sel_ram_o), 32'(prev_sel_o));
                if (prev_sel_o != SEL_NONE)
                    check({name, " stall r_addr"}, 32'(r_addr), 32'(prev_ra));
                check({name, " stall busy"}, 32'(busy), 32'd1);
                check({name, " stall done"}, 32'(done), 32'd0);
            end else begin
                k         = t - 1;
                exp_sel_o = (rd_mode && k < int'(len)) ? {1'b1, dir} : SEL_NONE;
                exp_ra    = 8'(int'(ra) + k * int'(st));
                kw        = (mode == MODE_RDWR) ? (t - 1 - int'(lat)) : k;
                exp_we    = (mode != MODE_READ) && kw >= 0 && kw < int'(len);
                exp_sel_i = !exp_we ? SEL_NONE :
                            (mode == MODE_RDWR) ? {1'b1, ~dir} : {1'b1, dir};
                exp_wa    = 8'(int'(wa) + kw * int'(st));
                check({name, " we_ram"},    32'(we_ram),    32'(exp_we));
                check({name, " sel_ram_i"}, 32'(sel_ram_i), 32'(exp_sel_i));
                check({name, " sel_ram_o"}, 32'(sel_ram_o), 32'(exp_sel_o));
                if (exp_sel_o != SEL_NONE) check({name, " r_addr"}, 32'(r_addr), 32'(exp_ra));
                if (exp_we)                check({name, " w_addr"}, 32'(w_addr), 32'(exp_wa));
                check({name, " busy"},      32'(busy), 32'd1);
                check({name, " done"},      32'(done), 32'd0);
                check({name, " cmd_ready"}, 32'(cmd_if.cmd_ready), 32'd0);
                prev_sel_o = exp_sel_o;
                if (exp_sel_o != SEL_NONE) prev_ra = exp_ra;
            end
            prev_stall = stall;
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        check({name, " finished in budget"}, 32'(fin), 32'd1);
    endtask

    initial begin
        logic [63:0] mask;
        logic [8:0]  rlen;

        rst               = 1'b1;
        stall             = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_mode   = 2'b00;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_raddr  = '0;
        cmd_if.cmd_waddr  = '0;
        cmd_if.cmd_stride = '0;
        cmd_if.cmd_len    = '0;
        cmd_if.cmd_lat    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // WRITE vertical, four consecutive writes at 0x10..0x13.
        run_cmd("write", MODE_WRITE, 1'b0, 8'h00, 8'h10, 8'd1, 9'd4, 4'd0, 64'd0, 1'b0);
        // READ horizontal wrapping past 0xFF.
        run_cmd("read_wrap", MODE_READ, 1'b1, 8'hFE, 8'h00, 8'd1, 9'd4, 4'd0, 64'd0, 1'b0);
        // RDWR with two-cycle write-back delay.
        run_cmd("rdwr_lat2", MODE_RDWR, 1'b0, 8'h00, 8'h40, 8'd2, 9'd3, 4'd2, 64'd0, 1'b0);
        // READ with stall high during beat 2 and the following bubble.
        run_cmd("read_stall", MODE_READ, 1'b0, 8'h20, 8'h00, 8'd3, 9'd5, 4'd0, 64'b1100, 1'b0);
        // Empty command with valid held high through DONE, then a real one.
        run_cmd("len0", MODE_READ, 1'b0, 8'h55, 8'h66, 8'd1, 9'd0, 4'd0, 64'd0, 1'b1);
        run_cmd("after_len0", MODE_READ, 1'b1, 8'h30, 8'h00, 8'd1, 9'd3, 4'd0, 64'd0, 1'b0);
        // Reserved mode acts as an empty burst.
        run_cmd("rsvd", MODE_RSVD, 1'b1, 8'h11, 8'h22, 8'd1, 9'd7, 4'd3, 64'd0, 1'b0);
        // Same-cycle read and write, and the longest delay.
        run_cmd("rdwr_lat0", MODE_RDWR, 1'b1, 8'h80, 8'h90, 8'd5, 9'd4, 4'd0, 64'd0, 1'b0);
        run_cmd("rdwr_lat15", MODE_RDWR, 1'b0, 8'hF0, 8'h08, 8'd7, 9'd2, 4'd15, 64'b100100, 1'b0);
        // Full-bank READ.
        run_cmd("read_full", MODE_READ, 1'b0, 8'h01, 8'h00, 8'd1, 9'd256, 4'd0, 64'd0, 1'b0);

        // Reset in the middle of an RDWR burst.
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = MODE_RDWR;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_raddr  = 8'h04;
        cmd_if.cmd_waddr  = 8'hA0;
        cmd_if.cmd_stride = 8'd1;
        cmd_if.cmd_len    = 9'd6;
        cmd_if.cmd_lat    = 4'd1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid burst we_ram", 32'(we_ram), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post rst");
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("post rst +1");
        @(posedge clk);
        #1;
        run_cmd("after_rst", MODE_WRITE, 1'b1, 8'h00, 8'hC0, 8'd4, 9'd3, 4'd0, 64'd0, 1'b0);

        // Randomized commands with random stall patterns.
        for (int i = 0; i < 24; i++) begin
            mask = {$urandom, $urandom} & {$urandom, $urandom};
            rlen = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
            run_cmd("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom), 8'($urandom), rlen,
                    4'($urandom_range(0, 15)), mask, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
